// File: rtl/sym_source_4ask_if.sv
// Symbol-source bus: symbol enable and switch settings in, transmitted symbol,
// valid strobe and delayed reference symbol out.
interface sym_source_4ask_if;
    logic              sym_clk;
    logic [3:0]        sw;
    logic signed [17:0] data_out;
    logic              sym_valid;
    logic signed [17:0] ref_out;

    modport master (
        input  sym_clk,
        input  sw,
        output data_out,
        output sym_valid,
        output ref_out
    );

    modport slave (
        output sym_clk,
        output sw,
        input  data_out,
        input  sym_valid,
        input  ref_out
    );
endinterface

// File: rtl/sym_source_4ask.sv
// 4-ASK test-symbol source (PRBS / constant / alternating / impulse) in 1s17,
// with a switch-selectable delayed copy of the symbol stream for receive-side comparison.
module sym_source_4ask #(
    parameter logic signed [17:0] LEVEL_HI       = 18'sd98304,
    parameter logic signed [17:0] LEVEL_LO       = 18'sd32768,
    parameter logic [21:0]        LFSR_SEED      = 22'h3FFFFF,
    parameter int unsigned        IMPULSE_PERIOD = 16,
    parameter int unsigned        REF_DELAY      = 8
) (
    input  logic             clk,
    input  logic             reset,
    sym_source_4ask_if.master bus
);

    localparam logic [1:0] MODE_PRBS  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_ALT   = 2'd2;
    localparam logic [1:0] MODE_IMP   = 2'd3;

    localparam int unsigned PIPE_DEPTH = REF_DELAY + 3;
    localparam int unsigned CW         = (IMPULSE_PERIOD > 2) ? $clog2(IMPULSE_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(IMPULSE_PERIOD - 1);

    logic [21:0]        lfsr;
    logic signed [17:0] data_q;
    logic               valid_q;
    logic signed [17:0] pipe [PIPE_DEPTH];
    logic               toggle;
    logic [CW-1:0]      imp_cnt;
    logic [1:0]         prev_mode;

    logic [1:0]         mode;
    logic               entering;
    logic               tog_eff;
    logic [CW-1:0]      cnt_eff;
    logic signed [17:0] prbs_sym;
    logic signed [17:0] next_data;
    logic signed [17:0] ref_sel;

    // Mode entry resets the per-mode state before it is used for this symbol.
    always_comb begin
        mode     = bus.sw[1:0];
        entering = (mode != prev_mode);
        tog_eff  = entering ? 1'b0 : toggle;
        cnt_eff  = entering ? '0 : imp_cnt;
    end

    always_comb begin
        prbs_sym = '0;
        case (lfsr[1:0])
            2'b00:   prbs_sym = -LEVEL_HI;
            2'b01:   prbs_sym = -LEVEL_LO;
            2'b11:   prbs_sym = LEVEL_LO;
            default: prbs_sym = LEVEL_HI;
        endcase
    end

    always_comb begin
        next_data = '0;
        case (mode)
            MODE_PRBS:  next_data = prbs_sym;
            MODE_CONST: next_data = LEVEL_HI;
            MODE_ALT:   next_data = tog_eff ? -LEVEL_HI : LEVEL_HI;
            default:    next_data = (cnt_eff == '0) ? LEVEL_HI : '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr      <= LFSR_SEED;
            data_q    <= '0;
            valid_q   <= 1'b0;
            toggle    <= 1'b0;
            imp_cnt   <= '0;
            prev_mode <= MODE_PRBS;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            valid_q <= bus.sym_clk;
            if (bus.sym_clk) begin
                lfsr      <= {lfsr[20:0], lfsr[21] ^ lfsr[20]};
                data_q    <= next_data;
                prev_mode <= mode;
                if (mode == MODE_ALT) begin
                    toggle <= ~tog_eff;
                end
                if (mode == MODE_IMP) begin
                    imp_cnt <= (cnt_eff == CNT_LAST) ? '0 : cnt_eff + CW'(1);
                end
                pipe[0] <= data_q;
                for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    // Tap select is combinational so a delay change is seen without flushing the pipe.
    always_comb begin
        ref_sel = '0;
        case (bus.sw[3:2])
            2'd0:    ref_sel = pipe[REF_DELAY-1];
            2'd1:    ref_sel = pipe[REF_DELAY];
            2'd2:    ref_sel = pipe[REF_DELAY+1];
            default: ref_sel = pipe[REF_DELAY+2];
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.sym_valid = valid_q;
    assign bus.ref_out   = ref_sel;

endmodule

// File: tb/tb_sym_source_4ask.sv
// Scoreboard bench for sym_source_4ask: an independent symbol model pushes expected
// data/ref pairs at each sym_clk, a per-cycle monitor pops and compares on sym_valid.
module tb_sym_source_4ask;

    localparam logic signed [17:0] HI = 18'sd98304;
    localparam logic signed [17:0] LO = 18'sd32768;
    localparam int                 PERIOD = 16;
    localparam int                 RDLY   = 8;

    typedef struct {
        logic signed [17:0] d;
        logic signed [17:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t               sb_q[$];
    logic signed [17:0] hist[$];
    logic [21:0]        m_lfsr;
    logic               m_tog;
    int                 m_cnt;
    logic [1:0]         m_prev;

    sym_source_4ask_if bus ();

    sym_source_4ask #(
        .LEVEL_HI(HI),
        .LEVEL_LO(LO),
        .LFSR_SEED(22'h3FFFFF),
        .IMPULSE_PERIOD(PERIOD),
        .REF_DELAY(RDLY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [17:0] model_ref(input logic [1:0] sel);
        int lag;
        int idx;
        lag = RDLY + int'(sel);
        idx = hist.size() - 1 - lag;
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    task automatic model_reset();
        m_lfsr = 22'h3FFFFF;
        m_tog  = 1'b0;
        m_cnt  = 0;
        m_prev = 2'd0;
        hist.delete();
        sb_q.delete();
    endtask

    task automatic model_step(input logic [3:0] s);
        logic signed [17:0] d;
        logic               ent;
        logic               t;
        int                 c;
        exp_t               e;
        ent = (s[1:0] != m_prev);
        case (s[1:0])
            2'd0: begin
                case (m_lfsr[1:0])
                    2'b00: d = -HI;
                    2'b01: d = -LO;
                    2'b11: d = LO;
                    default: d = HI;
                endcase
            end
            2'd1: d = HI;
            2'd2: begin
                t = ent ? 1'b0 : m_tog;
                d = t ? -HI : HI;
                m_tog = ~t;
            end
            default: begin
                c = ent ? 0 : m_cnt;
                d = (c == 0) ? HI : 18'sd0;
                m_cnt = (c + 1) % PERIOD;
            end
        endcase
        m_lfsr = {m_lfsr[20:0], m_lfsr[21] ^ m_lfsr[20]};
        m_prev = s[1:0];
        hist.push_back(d);
        e.d = d;
        e.r = model_ref(s[3:2]);
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge with sym_clk low.
    task automatic sym_beat(input logic [3:0] s);
        bus.sw      = s;
        bus.sym_clk = 1'b1;
        model_step(s);
        @(negedge clk);
        bus.sym_clk = 1'b0;
    endtask

    task automatic syms(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            sym_beat(s);
            @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        logic sc;
        exp_t e;
        sc = bus.sym_clk;
        #2;
        if (!reset) begin
            check("sym_valid", bus.sym_valid, sc);
            if (bus.sym_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("data_out", bus.data_out, e.d);
                    check("ref_out", bus.ref_out, e.r);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bus.sym_clk = 1'b0;
        bus.sw      = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_data", bus.data_out, 0);
        check("rst_ref", bus.ref_out, 0);
        check("rst_valid", bus.sym_valid, 0);
        @(negedge clk);

        // PRBS from seed: +LO, +HI, -HI, -HI
        syms(4'd0, 4);
        check("lfsr_after4", dut.lfsr, 22'h3FFFF0);
        syms(4'd0, 12);

        syms(4'd2, 4);
        syms(4'd1, 3);
        // sw wiggle between symbols must not register as a mode entry
        bus.sw = 4'd3;
        repeat (3) @(negedge clk);
        syms(4'd1, 2);
        syms(4'd0, 6);

        // delay select change while idle: tap moves with no pipe flush
        bus.sw = 4'b1100;
        #1;
        check("ref_sel3_idle", bus.ref_out, model_ref(2'd3));
        @(negedge clk);
        syms(4'b1100, 10);
        syms(4'd0, 3);

        // asynchronous reset between edges
        #1 reset = 1'b1;
        #1;
        check("midrst_data", bus.data_out, 0);
        check("midrst_ref", bus.ref_out, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        syms(4'd0, 4);

        syms(4'd3, 40);

        // back-to-back symbols
        for (int i = 0; i < 8; i++) begin
            sym_beat(4'd0);
        end
        repeat (4) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/sym_source_4ask.md
Name: sym_source_4ask

Overview:
- Transmit-end test source that feeds the comm SUT `data_in`: one 4-ASK symbol per `sym_clk` enable, in 1s17 format.
- Patterns: 22-bit PRBS, constant, alternating, or periodic impulse.
- Also drives a programmable-delay copy of the transmitted symbol stream (`ref_out`). The receive-side error/MER accumulator compares `ref_out` against the SUT `data_out`.

Parameters:
- LEVEL_HI, 18'sd98304, outer constellation magnitude (0.75 in 1s17).
- LEVEL_LO, 18'sd32768, inner constellation magnitude (0.25 in 1s17).
- LFSR_SEED, 22'h3FFFFF, LFSR reset value; must be nonzero.
- IMPULSE_PERIOD, 16, symbols per impulse period in mode 3 (≥2).
- REF_DELAY, 8, base reference delay in symbols (≥1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- sym_clk  input  1  symbol-rate enable; one clk cycle wide.
- sw  input  4  sw[1:0] = pattern mode; sw[3:2] = extra reference delay, 0..3 symbols.
- data_out  output  18 signed  symbol to the SUT, 1s17.
- sym_valid  output  1  one-cycle pulse: data_out updated this cycle.
- ref_out  output  18 signed  delayed copy of the data_out symbol stream.

Behaviour:
- Reset (async, active-high):
  - lfsr = LFSR_SEED; data_out = 0; sym_valid = 0; all ref pipe stages = 0.
  - toggle flag = 0; impulse counter = 0; prev_mode = 2'd0.
- All state advances only on clk edges where sym_clk = 1. Exception: sym_valid is a registered copy of sym_clk (it goes high the cycle after the sym_clk cycle, when the new data_out is visible).
- LFSR, Fibonacci, polynomial x^22+x^21+1:
  - on each sym_clk: new = lfsr[21]^lfsr[20]; lfsr <= {lfsr[20:0], new}.
  - runs in every mode, so PRBS continuity is kept across mode changes.
- Gray map of the current (pre-update) lfsr[1:0]: 00→-LEVEL_HI, 01→-LEVEL_LO, 11→+LEVEL_LO, 10→+LEVEL_HI.
- data_out update on sym_clk, by sw[1:0] sampled in that cycle:
  - 0 PRBS: map(lfsr[1:0]).
  - 1 constant: +LEVEL_HI.
  - 2 alternating: output is toggle ? -LEVEL_HI : +LEVEL_HI; toggle then inverts. Toggle is cleared to 0 when entering mode 2, so the first symbol is +LEVEL_HI.
  - 3 impulse: +LEVEL_HI when count == 0, else 0. count increments and wraps IMPULSE_PERIOD-1 → 0. count is cleared to 0 when entering mode 3, so the first symbol is the impulse.
- Mode entry:
  - detected on a sym_clk where sw[1:0] != prev_mode; prev_mode <= sw[1:0] on every sym_clk.
  - changes of sw between sym_clk pulses have no effect until the next sym_clk.
- Reference pipe, depth REF_DELAY+3:
  - on sym_clk: pipe[0] <= data_out (value before this update); pipe[i] <= pipe[i-1].
  - ref_out = pipe[REF_DELAY-1+sw[3:2]], combinational mux.
  - so ref_out equals data_out from (REF_DELAY+sw[3:2]) symbols earlier.
  - changing sw[3:2] takes effect immediately; pipe contents are preserved.
- Reset asserted mid-stream: all of the above return to reset values immediately. The first sym_clk after deassertion reproduces the post-reset sequence exactly.
- Back-to-back sym_clk (every cycle) is legal; one symbol per asserted cycle.
- Width rules: all outputs are exact constants or copies; no arithmetic and no saturation.

Test Plan:
- Reset, then mode 0 with 4 sym_clk pulses → data_out = +32768, +98304, -98304, -98304; lfsr = 3FFFFE, 3FFFFC, 3FFFF8, 3FFFF0; sym_valid pulses once per symbol, one cycle after sym_clk.
- Mode 2 after mode 0, 4 symbols → +98304, -98304, +98304, -98304. Switch to mode 1 → +98304 each symbol. Return to mode 0 → PRBS resumes from the advanced LFSR state, not the seed.
- Mode 3, IMPULSE_PERIOD=16, 40 symbols → +98304 at symbol indices 0, 16, 32; 0 elsewhere.
- REF_DELAY=8, mode 0:
  - sw[3:2]=0 → ref_out matches data_out from 8 symbols earlier, and is 0 for the first 8 symbols.
  - set sw[3:2]=3 → 11-symbol lag with no reset of the pipe.
- Assert reset mid-PRBS for 1 cycle (async, between clk edges) → data_out/ref_out = 0 immediately; the next 4 symbols equal +32768, +98304, -98304, -98304.
- sym_clk held high for 8 consecutive cycles → 8 distinct symbol updates; sym_valid high for 8 cycles; no symbol is skipped or duplicated.
